// File: rtl/tuner_seq_ctrl.sv
// Ring tuner sequencer: search sweep, pick the configured peak, trigger lock, supervise
// tracking, and re-run the whole sequence on failure with a bounded retry count.
module tuner_seq_ctrl #(
  parameter int DAC_WIDTH   = 8,
  parameter int ADC_WIDTH   = 8,
  parameter int NUM_TARGET  = 8,
  parameter int RETRY_WIDTH = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  input  logic                                 i_stop,
  input  logic [$clog2(NUM_TARGET)-1:0]        i_cfg_target_idx,
  input  logic [RETRY_WIDTH-1:0]               i_cfg_max_retry,
  output logic                                 o_search_trig_val,
  input  logic                                 i_search_trig_rdy,
  input  logic                                 i_search_peaks_val,
  output logic                                 o_search_peaks_rdy,
  input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] i_search_ring_tune_peaks,
  input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] i_search_pwr_peaks,
  input  logic [$clog2(NUM_TARGET):0]          i_search_peaks_cnt,
  input  logic                                 i_search_err,
  output logic                                 o_lock_trig_val,
  input  logic                                 i_lock_trig_rdy,
  input  logic                                 i_lock_track_val,
  output logic                                 o_lock_track_rdy,
  input  logic                                 i_lock_err,
  output logic [DAC_WIDTH-1:0]                 o_cfg_ring_tune_peak,
  output logic [ADC_WIDTH-1:0]                 o_cfg_pwr_peak,
  output logic [2:0]                           o_state,
  output logic                                 o_locked,
  output logic                                 o_fail,
  output logic [RETRY_WIDTH-1:0]               o_retry_cnt
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEARCH_TRIG = 3'd1,
    SEARCH_WAIT = 3'd2,
    SELECT      = 3'd3,
    LOCK_TRIG   = 3'd4,
    TRACK       = 3'd5,
    FAIL        = 3'd6
  } state_t;

  state_t                 state, state_nxt;
  logic [RETRY_WIDTH-1:0] retry_cnt, retry_nxt;
  logic                   locked, locked_nxt;
  logic                   fail, fail_nxt;
  logic                   latch;
  logic                   fail_evt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                <= IDLE;
      retry_cnt            <= '0;
      locked               <= 1'b0;
      fail                 <= 1'b0;
      o_cfg_ring_tune_peak <= '0;
      o_cfg_pwr_peak       <= '0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      locked    <= locked_nxt;
      fail      <= fail_nxt;
      if (latch) begin
        o_cfg_ring_tune_peak <= i_search_ring_tune_peaks[i_cfg_target_idx];
        o_cfg_pwr_peak       <= i_search_pwr_peaks[i_cfg_target_idx];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    retry_nxt  = retry_cnt;
    locked_nxt = locked;
    fail_nxt   = fail;
    latch      = 1'b0;
    fail_evt   = 1'b0;
    if (i_stop) begin
      state_nxt  = IDLE;
      locked_nxt = 1'b0;
      fail_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE, FAIL: if (i_start) begin
          retry_nxt = '0;
          fail_nxt  = 1'b0;
          state_nxt = SEARCH_TRIG;
        end
        SEARCH_TRIG: if (i_search_trig_rdy) state_nxt = SEARCH_WAIT;
        // an error flag wins over a peak list presented in the same cycle
        SEARCH_WAIT: begin
          if (i_search_err) fail_evt = 1'b1;
          else if (i_search_peaks_val) begin
            if (i_search_peaks_cnt > {1'b0, i_cfg_target_idx}) begin
              latch     = 1'b1;
              state_nxt = SELECT;
            end else fail_evt = 1'b1;
          end
        end
        SELECT: state_nxt = LOCK_TRIG;
        LOCK_TRIG: begin
          if (i_lock_err) fail_evt = 1'b1;
          else if (i_lock_trig_rdy) state_nxt = TRACK;
        end
        TRACK: begin
          if (i_lock_err) fail_evt = 1'b1;
          else if (i_lock_track_val && !locked) begin
            locked_nxt = 1'b1;
            retry_nxt  = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (fail_evt) begin
        locked_nxt = 1'b0;
        if (retry_cnt == i_cfg_max_retry) begin
          state_nxt = FAIL;
          fail_nxt  = 1'b1;
        end else begin
          state_nxt = SEARCH_TRIG;
          if (retry_cnt != '1) retry_nxt = retry_cnt + RETRY_WIDTH'(1);
        end
      end
    end
  end

  assign o_search_trig_val  = (state == SEARCH_TRIG);
  assign o_search_peaks_rdy = (state == SEARCH_WAIT);
  assign o_lock_trig_val    = (state == LOCK_TRIG);
  assign o_lock_track_rdy   = (state == TRACK);
  assign o_state            = state;
  assign o_locked           = locked;
  assign o_fail             = fail;
  assign o_retry_cnt        = retry_cnt;

endmodule
